// File: rtl/crc32_d32_if.sv
// crc32_d32_if: word stream into the CRC block and running CRC back out
// i_d/i_d_vld: data word and its strobe; i_clr: restart the CRC; o_crc: register contents
interface crc32_d32_if;
  logic [31:0] i_d;
  logic        i_d_vld;
  logic        i_clr;
  logic [31:0] o_crc;
  modport master (output i_d, i_d_vld, i_clr, input o_crc);
  modport slave (input i_d, i_d_vld, i_clr, output o_crc);
endinterface

// File: rtl/crc32_d32.sv
// crc32_d32: one-word-per-clock MSB-first CRC-32 (0x04C11DB7), augmented form, zero init
// i_clk/i_rst: clock and sync active-high reset; bus: crc32_d32_if slave (i_d, i_d_vld, i_clr in, o_crc out)
module crc32_d32 (
  input logic         i_clk,
  input logic         i_rst,
  crc32_d32_if.slave  bus
);
  localparam logic [31:0] POLY = 32'h04C1_1DB7;
  logic [31:0] crc_q, crc_d;
  // Data bits enter at the low end, so a word into a zero register comes straight out.
  function automatic logic [31:0] crc_step(input logic [31:0] r, input logic [31:0] d);
    logic fb;
    for (int b = 31; b >= 0; b--) begin
      fb = r[31];
      r  = {r[30:0], d[b]};
      r  = fb ? r ^ POLY : r;
    end
    return r;
  endfunction
  always_comb begin
    crc_d = bus.i_clr ? 32'h0 : bus.i_d_vld ? crc_step(crc_q, bus.i_d) : crc_q;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) crc_q <= 32'h0;
    else       crc_q <= crc_d;
  end
  assign bus.o_crc = crc_q;
endmodule

// File: tb/tb_crc32_d32.sv
// tb_crc32_d32: directed self-checking bench for crc32_d32
module tb_crc32_d32;
  logic i_clk = 1'b0;
  logic i_rst;
  int checks = 0;
  int errors = 0;
  crc32_d32_if bus ();
  crc32_d32 dut (.i_clk(i_clk), .i_rst(i_rst), .bus(bus));
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic absorb(input logic [31:0] d);
    bus.i_d = d;
    bus.i_d_vld = 1'b1;
    tick();
    bus.i_d_vld = 1'b0;
  endtask

  task automatic clear();
    bus.i_clr = 1'b1;
    tick();
    bus.i_clr = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    bus.i_d = 32'hFFFF_FFFF;
    bus.i_d_vld = 1'b1;
    bus.i_clr = 1'b0;
    tick();
    tick();
    i_rst = 1'b0;
    bus.i_d_vld = 1'b0;
    checks++;
    if (bus.o_crc !== 32'h0) begin
      errors++;
      $display("FAIL reset: got %h expected %h", bus.o_crc, 32'h0);
    end
  endtask

  // word w from zero gives w; a following zero word gives w*x^32 mod G
  task automatic test_single_words();
    logic [31:0] w [5] = '{32'h1, 32'h2, 32'h40, 32'h80, 32'h3};
    logic [31:0] e [5] = '{32'h04C11DB7, 32'h09823B6E, 32'h34867077, 32'h690CE0EE, 32'h0D4326D9};
    for (int i = 0; i < 5; i++) begin
      clear();
      absorb(w[i]);
      checks++;
      if (bus.o_crc !== w[i]) begin
        errors++;
        $display("FAIL word_%0d: got %h expected %h", i, bus.o_crc, w[i]);
      end
      absorb(32'h0);
      checks++;
      if (bus.o_crc !== e[i]) begin
        errors++;
        $display("FAIL crc_%0d: got %h expected %h", i, bus.o_crc, e[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear();
    absorb(32'h1);
    absorb(32'h1234_5678);
    checks++;
    if (bus.o_crc !== 32'h16F54BCF) begin
      errors++;
      $display("FAIL back_to_back: got %h expected %h", bus.o_crc, 32'h16F54BCF);
    end
  endtask

  task automatic test_check_word();
    clear();
    absorb(32'h1);
    absorb(32'h04C11DB7);
    checks++;
    if (bus.o_crc !== 32'h0) begin
      errors++;
      $display("FAIL check_word: got %h expected %h", bus.o_crc, 32'h0);
    end
  endtask

  task automatic test_roundtrip();
    logic [31:0] words [100];
    logic [31:0] cap;
    for (int i = 0; i < 100; i++) words[i] = $urandom;
    clear();
    for (int i = 0; i < 100; i++) absorb(words[i]);
    absorb(32'h0);
    cap = bus.o_crc;
    clear();
    for (int i = 0; i < 100; i++) absorb(words[i]);
    absorb(cap);
    checks++;
    if (bus.o_crc !== 32'h0) begin
      errors++;
      $display("FAIL roundtrip: got %h expected %h", bus.o_crc, 32'h0);
    end
  endtask

  task automatic test_hold();
    clear();
    absorb(32'h1);
    absorb(32'hA5A5_A5A5);
    for (int i = 0; i < 5; i++) begin
      bus.i_d = (i % 2 == 0) ? 32'hFFFF_FFFF : 32'h1357_9BDF;
      tick();
      checks++;
      if (bus.o_crc !== 32'hA164B812) begin
        errors++;
        $display("FAIL hold_%0d: got %h expected %h", i, bus.o_crc, 32'hA164B812);
      end
    end
  endtask

  task automatic test_clr_priority();
    clear();
    absorb(32'h1);
    absorb(32'h0);
    bus.i_clr = 1'b1;
    bus.i_d_vld = 1'b1;
    bus.i_d = 32'hDEAD_BEEF;
    tick();
    bus.i_clr = 1'b0;
    bus.i_d_vld = 1'b0;
    checks++;
    if (bus.o_crc !== 32'h0) begin
      errors++;
      $display("FAIL clr_over_vld: got %h expected %h", bus.o_crc, 32'h0);
    end
    absorb(32'h5);
    checks++;
    if (bus.o_crc !== 32'h5) begin
      errors++;
      $display("FAIL after_clr: got %h expected %h", bus.o_crc, 32'h5);
    end
  endtask

  task automatic test_rst_midstream();
    clear();
    absorb(32'h1);
    absorb(32'h2);
    checks++;
    if (bus.o_crc !== 32'h04C11DB5) begin
      errors++;
      $display("FAIL pre_rst: got %h expected %h", bus.o_crc, 32'h04C11DB5);
    end
    i_rst = 1'b1;
    bus.i_d_vld = 1'b1;
    bus.i_d = 32'hDEAD_BEEF;
    tick();
    i_rst = 1'b0;
    bus.i_d_vld = 1'b0;
    checks++;
    if (bus.o_crc !== 32'h0) begin
      errors++;
      $display("FAIL rst_midstream: got %h expected %h", bus.o_crc, 32'h0);
    end
    absorb(32'h1);
    absorb(32'h0);
    checks++;
    if (bus.o_crc !== 32'h04C11DB7) begin
      errors++;
      $display("FAIL after_rst: got %h expected %h", bus.o_crc, 32'h04C11DB7);
    end
  endtask

  initial begin
    test_reset();
    test_single_words();
    test_back_to_back();
    test_check_word();
    test_roundtrip();
    test_hold();
    test_clr_priority();
    test_rst_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
